// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID bring-up checker.
package sysid_check_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_RD_TS,
    S_CHECK,
    S_DONE
  } state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;
  localparam int   TMR_W         = 16;
  localparam int   RTRY_W        = 3;
endpackage

// File: rtl/sysid_check_timer.sv
// Stall counter for one Avalon read attempt; expire fires on the
// TIMEOUT_CYCLES-th consecutive stalled cycle.
module sysid_check_timer
  import sysid_check_pkg::*;
#(
  parameter logic [TMR_W-1:0] TIMEOUT_CYCLES = 16'd1023
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + TMR_W'(1);
  end

  assign expire = enable && (cnt == TIMEOUT_CYCLES - TMR_W'(1));
endmodule

// File: rtl/sysid_check_ctrl.sv
// Reads sysid word 0 (ID) and word 1 (timestamp) over Avalon-MM and compares
// them to build constants. Define SYSID_CHECK_AUTOSTART_EN to self-start after reset.
module sysid_check_ctrl
  import sysid_check_pkg::*;
#(
  parameter logic [31:0]      EXPECTED_ID        = 32'd0,
  parameter logic [31:0]      EXPECTED_TIMESTAMP = 32'd1624360340,
  parameter logic [TMR_W-1:0] TIMEOUT_CYCLES     = 16'd1023,
  parameter int               MAX_RETRIES        = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] read_id,
  output logic [31:0] read_ts
);
  state_e            state, nxt_state;
  logic              gap, nxt_gap;
  logic [RTRY_W-1:0] retry, nxt_retry;
  logic              nxt_busy, nxt_done, nxt_pass, nxt_id_mm, nxt_ts_mm, nxt_timeout;
  logic              nxt_avm_read, nxt_avm_address;
  logic [31:0]       nxt_read_id, nxt_read_ts;
  logic              stalled, accept, tmr_expire, auto_start, start_eff;

  assign stalled   = avm_read && avm_waitrequest;
  assign accept    = avm_read && !avm_waitrequest;
  assign start_eff = start || auto_start;

`ifdef SYSID_CHECK_AUTOSTART_EN
  logic auto_fired;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) auto_fired <= 1'b0;
    else          auto_fired <= 1'b1;
  end
  assign auto_start = !auto_fired;
`else
  assign auto_start = 1'b0;
`endif

  sysid_check_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (!stalled),
    .enable (stalled),
    .expire (tmr_expire)
  );

  always_comb begin
    nxt_state   = state;
    nxt_gap     = gap;
    nxt_retry   = retry;
    nxt_busy    = busy;
    nxt_done    = done;
    nxt_pass    = pass;
    nxt_id_mm   = id_mismatch;
    nxt_ts_mm   = ts_mismatch;
    nxt_timeout = timeout;
    nxt_read_id = read_id;
    nxt_read_ts = read_ts;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_eff) begin
          nxt_state   = S_RD_ID;
          nxt_gap     = 1'b0;
          nxt_retry   = '0;
          nxt_busy    = 1'b1;
          nxt_done    = 1'b0;
          nxt_pass    = 1'b0;
          nxt_id_mm   = 1'b0;
          nxt_ts_mm   = 1'b0;
          nxt_timeout = 1'b0;
        end
      end
      S_RD_ID, S_RD_TS: begin
        if (gap) begin
          nxt_gap = 1'b0;
        end else if (accept) begin
          if (state == S_RD_ID) begin
            nxt_read_id = avm_readdata;
            nxt_state   = S_RD_TS;
          end else begin
            nxt_read_ts = avm_readdata;
            nxt_state   = S_CHECK;
          end
        end else if (tmr_expire) begin
          // Retry budget is shared by both reads of one check.
          if (retry == RTRY_W'(MAX_RETRIES)) begin
            nxt_timeout = 1'b1;
            nxt_busy    = 1'b0;
            nxt_done    = 1'b1;
            nxt_state   = S_DONE;
          end else begin
            nxt_retry = retry + RTRY_W'(1);
            nxt_gap   = 1'b1;
          end
        end
      end
      S_CHECK: begin
        nxt_id_mm = (read_id != EXPECTED_ID);
        nxt_ts_mm = (read_ts != EXPECTED_TIMESTAMP);
        nxt_pass  = (read_id == EXPECTED_ID) && (read_ts == EXPECTED_TIMESTAMP);
        nxt_busy  = 1'b0;
        nxt_done  = 1'b1;
        nxt_state = S_DONE;
      end
      default: nxt_state = S_IDLE;
    endcase
    nxt_avm_read    = ((nxt_state == S_RD_ID) || (nxt_state == S_RD_TS)) && !nxt_gap;
    nxt_avm_address = (nxt_state == S_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      gap         <= 1'b0;
      retry       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      read_id     <= '0;
      read_ts     <= '0;
      avm_read    <= 1'b0;
      avm_address <= SYSID_ADDR_ID;
    end else begin
      state       <= nxt_state;
      gap         <= nxt_gap;
      retry       <= nxt_retry;
      busy        <= nxt_busy;
      done        <= nxt_done;
      pass        <= nxt_pass;
      id_mismatch <= nxt_id_mm;
      ts_mismatch <= nxt_ts_mm;
      timeout     <= nxt_timeout;
      read_id     <= nxt_read_id;
      read_ts     <= nxt_read_ts;
      avm_read    <= nxt_avm_read;
      avm_address <= nxt_avm_address;
    end
  end
endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Directed bench for sysid_check_ctrl with a small stall-programmable sysid slave.
module tb_sysid_check_ctrl;
  localparam logic [31:0] TS_OK = 32'd1624360340;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
  logic [31:0] read_id, read_ts;

  logic [31:0] id_val = 32'd0;
  logic [31:0] ts_val = TS_OK;
  int          stall_n = 0;
  logic        stuck = 1'b0;
  int          stall_cnt = 0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  sysid_check_ctrl #(
    .EXPECTED_ID       (32'd0),
    .EXPECTED_TIMESTAMP(TS_OK),
    .TIMEOUT_CYCLES    (16'd8),
    .MAX_RETRIES       (2)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .id_mismatch    (id_mismatch),
    .ts_mismatch    (ts_mismatch),
    .timeout        (timeout),
    .read_id        (read_id),
    .read_ts        (read_ts)
  );

  // Slave stalls each read for stall_n cycles, or forever while stuck.
  assign avm_waitrequest = stuck || (avm_read && (stall_cnt < stall_n));
  assign avm_readdata    = avm_address ? ts_val : id_val;

  always @(posedge clock) begin
    if (avm_read && avm_waitrequest) stall_cnt <= stall_cnt + 1;
    else                             stall_cnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulses start in cycle 0 and walks until done; cyc is the cycle done is seen.
  task automatic run_check(input int inj_at, output int cyc, output int rises,
                           output int gaps, output int glitches);
    logic pr, pa, pst;
    cyc = 0; rises = 0; gaps = 0; glitches = 0;
    pr = avm_read; pa = avm_address; pst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc++;
      if (avm_read && !pr) rises++;
      if (busy && !avm_read) gaps++;
      if (pst && avm_read && (avm_address != pa)) glitches++;
      pst = avm_read && avm_waitrequest;
      pa  = avm_address;
      pr  = avm_read;
      if (done) break;
      start = (cyc == inj_at);
      tick();
    end
    start = 1'b0;
  endtask

  // Releases reset; with autostart the implicit check must finish in 4 cycles.
  task automatic release_reset();
    int c;
    reset_n = 1'b1;
`ifdef SYSID_CHECK_AUTOSTART_EN
    c = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      c++;
      if (done) break;
    end
    chk("autostart_cycles", 32'(c), 32'd4);
    chk("autostart_pass", {31'd0, pass}, 32'd1);
`else
    c = 0;
    tick();
    chk("idle_no_autostart", {31'd0, busy}, 32'd0);
`endif
  endtask

  initial begin
    int cyc, rises, gaps, gl;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_read", {31'd0, avm_read}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_read_ts", read_ts, 32'd0);
    release_reset();

    // Zero-stall slave with matching image.
    run_check(-1, cyc, rises, gaps, gl);
    chk("zs_cycles", 32'(cyc), 32'd4);
    chk("zs_pass", {31'd0, pass}, 32'd1);
    chk("zs_read_id", read_id, 32'd0);
    chk("zs_read_ts", read_ts, TS_OK);
    chk("zs_busy", {31'd0, busy}, 32'd0);
    chk("zs_flags", {29'd0, id_mismatch, ts_mismatch, timeout}, 32'd0);

    // Five stall cycles per read; start mid-check must be ignored.
    stall_n = 5;
    run_check(3, cyc, rises, gaps, gl);
    chk("st_cycles", 32'(cyc), 32'd14);
    chk("st_pass", {31'd0, pass}, 32'd1);
    chk("st_addr_stable", 32'(gl), 32'd0);
    chk("st_attempts", 32'(rises), 32'd1);
    stall_n = 0;

    // Wrong ID word.
    id_val = 32'h0000_0001;
    run_check(-1, cyc, rises, gaps, gl);
    chk("id_mm", {31'd0, id_mismatch}, 32'd1);
    chk("id_ts_mm", {31'd0, ts_mismatch}, 32'd0);
    chk("id_pass", {31'd0, pass}, 32'd0);
    chk("id_read_id", read_id, 32'h1);

    // Wrong timestamp word.
    id_val = 32'd0;
    ts_val = 32'hDEAD_BEEF;
    run_check(-1, cyc, rises, gaps, gl);
    chk("ts_mm", {31'd0, ts_mismatch}, 32'd1);
    chk("ts_id_mm", {31'd0, id_mismatch}, 32'd0);
    chk("ts_pass", {31'd0, pass}, 32'd0);
    chk("ts_read_ts", ts_val, read_ts);

    // Stuck slave: 3 attempts of 8 stalled cycles, 1-cycle gaps, then timeout.
    ts_val = TS_OK;
    id_val = 32'h0000_00AA;
    stuck  = 1'b1;
    run_check(-1, cyc, rises, gaps, gl);
    chk("to_cycles", 32'(cyc), 32'd27);
    chk("to_timeout", {31'd0, timeout}, 32'd1);
    chk("to_done", {31'd0, done}, 32'd1);
    chk("to_pass", {31'd0, pass}, 32'd0);
    chk("to_attempts", 32'(rises), 32'd3);
    chk("to_gaps", 32'(gaps), 32'd2);
    chk("to_id_mm", {31'd0, id_mismatch}, 32'd0);
    chk("to_read_id_kept", read_id, 32'd0);
    stuck  = 1'b0;
    id_val = 32'd0;

    // Reset in the middle of the timestamp read.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("mid_in_rd_ts", {30'd0, avm_read, avm_address}, 32'd3);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_read", {31'd0, avm_read}, 32'd0);
    chk("mid_rst_addr", {31'd0, avm_address}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_timeout", {31'd0, timeout}, 32'd0);
    chk("mid_rst_read_id", read_id, 32'd0);
    tick();
    release_reset();
    run_check(-1, cyc, rises, gaps, gl);
    chk("post_rst_cycles", 32'(cyc), 32'd4);
    chk("post_rst_pass", {31'd0, pass}, 32'd1);
    chk("post_rst_read_ts", read_ts, TS_OK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
